ebox_mem_responder: RTL

- MBOX-side responder for the EBOX memory request interface.
- Accepts EBOX_REQ with VMA, read/write/read-pause-write qualifiers and write data.
- Services each request from a local word-addressed backing RAM after a fixed latency, then returns the completion handshake (T0, response strobe, read data, NXM).
- Stands in for the cache/core path in EBOX bring-up and simulation builds.

---
 rtl/ebox_mem_responder_if.sv | 29 ++
 rtl/ebox_mem_responder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ebox_mem_responder_if.sv
// EBOX <-> MBOX memory request bundle.
// Word bit numbering: PDP-10 bit n of a field is vector bit (35 - n), so
// EBOX_VMA[0] is VMA bit 35 (LSB) and EBOX_VMA[22] is VMA bit 13.
// The data words use the same mapping over [35:0].
interface ebox_mem_responder_if;
  logic        EBOX_REQ;
  logic        eboxRead;
  logic        eboxWrite;
  logic        eboxPSE;
  logic [22:0] EBOX_VMA;
  logic [35:0] cacheDataWrite;
  logic        cshEBOXT0;
  logic        mboxRespIn;
  logic [35:0] cacheDataRead;
  logic        nxmErr;
  logic        cshEBOXRetry;

  // EBOX side: issues requests, observes the completion handshake.
  modport master (
    output EBOX_REQ, eboxRead, eboxWrite, eboxPSE, EBOX_VMA, cacheDataWrite,
    input  cshEBOXT0, mboxRespIn, cacheDataRead, nxmErr, cshEBOXRetry
  );

  // MBOX side: the responder.
  modport slave (
    input  EBOX_REQ, eboxRead, eboxWrite, eboxPSE, EBOX_VMA, cacheDataWrite,
    output cshEBOXT0, mboxRespIn, cacheDataRead, nxmErr, cshEBOXRetry
  );
endinterface

// File: rtl/ebox_mem_responder.sv
// ebox_mem_responder: MBOX-side stand-in for the cache/core path.
// Accepts one EBOX request at a time, services it from a local word RAM
// after LATENCY cycles and returns the completion handshake.
// cshEBOXT0 is decoded from the state and the live request so that it lands
// in the acceptance cycle; every other output is registered.
// Optional feature: define EBOX_MEM_RETRY_INJECT_EN to answer every
// RETRY_PERIOD-th accepted request with cshEBOXRetry instead of a completion.
// Bit numbering follows ebox_mem_responder_if (vector bit 0 = PDP-10 bit 35).
module ebox_mem_responder #(
  parameter int ADDR_BITS    = 14,
  parameter int LATENCY      = 3,
  parameter int RETRY_PERIOD = 5
) (
  input  logic                 clk,
  input  logic                 FPGA_RESET,
  ebox_mem_responder_if.slave  ebox
);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2, PSE_HOLD = 2'd3} state_t;

  if (ADDR_BITS < 4 || ADDR_BITS > 23 || LATENCY < 1 || RETRY_PERIOD < 2) begin : g_param_check
    $error("ebox_mem_responder: parameter out of range");
  end

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [ADDR_BITS-1:0] idx_q, lock_idx_q;
  logic [35:0]          wdata_q, rdata_q;
  logic                 rd_q, nxm_q, pse_q, pse_wr_q, retry_q;
  logic                 resp_q, nxm_err_q, retry_out_q, rd_valid_q;
  logic [35:0]          mem [DEPTH];

  logic                 accept_idle, accept_pse, accept;
  logic                 acc_rd, acc_nxm, acc_retry, vma_nxm;
  logic [ADDR_BITS-1:0] acc_idx, idx_d;
  logic                 rd_d, nxm_d, retry_d, enter_resp, mem_we;

  // Any VMA bit above the RAM index marks a nonexistent address.
  if (ADDR_BITS < 23) begin : g_nxm
    assign vma_nxm = |ebox.EBOX_VMA[22:ADDR_BITS];
  end else begin : g_no_nxm
    assign vma_nxm = 1'b0;
  end

  // In IDLE read or write is accepted; under a PSE lock only a write gets in.
  assign accept_idle = (state_q == IDLE) && ebox.EBOX_REQ && (ebox.eboxRead || ebox.eboxWrite);
  assign accept_pse  = (state_q == PSE_HOLD) && ebox.EBOX_REQ && ebox.eboxWrite;
  assign accept      = (accept_idle || accept_pse) && !FPGA_RESET;

  // Read wins when both qualifiers are set; a PSE write is pinned to the lock.
  assign acc_rd  = accept_idle && ebox.eboxRead;
  assign acc_idx = accept_pse ? lock_idx_q : ebox.EBOX_VMA[ADDR_BITS-1:0];
  assign acc_nxm = accept_idle && vma_nxm;

  // Request fields as they will stand after this edge.
  assign idx_d   = accept ? acc_idx   : idx_q;
  assign rd_d    = accept ? acc_rd    : rd_q;
  assign nxm_d   = accept ? acc_nxm   : nxm_q;
  assign retry_d = accept ? acc_retry : retry_q;

  assign enter_resp = (accept && (LATENCY == 1)) || ((state_q == BUSY) && (cnt_q == CW'(1)));
  assign mem_we     = (state_q == RESP) && !rd_q && !nxm_q && !retry_q && !FPGA_RESET;

`ifdef EBOX_MEM_RETRY_INJECT_EN
  localparam int RW = $clog2(RETRY_PERIOD);
  logic [RW-1:0] retry_cnt_q;

  assign acc_retry = (retry_cnt_q == RW'(RETRY_PERIOD - 1));

  // Count accepted requests modulo RETRY_PERIOD; the wrap acceptance is retried.
  always_ff @(posedge clk) begin
    if (FPGA_RESET) begin
      retry_cnt_q <= '0;
    end else if (accept) begin
      retry_cnt_q <= acc_retry ? '0 : retry_cnt_q + RW'(1);
    end
  end
`else
  assign acc_retry = 1'b0;
`endif

  // Backing RAM: no reset, registered read addressed by the next request index
  // so the word is ready in the response cycle even at LATENCY=1.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
    rdata_q <= mem[idx_d];
  end

  // Request FSM with registered completion outputs.
  always_ff @(posedge clk) begin
    if (FPGA_RESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      lock_idx_q  <= '0;
      wdata_q     <= '0;
      rd_q        <= 1'b0;
      nxm_q       <= 1'b0;
      pse_q       <= 1'b0;
      pse_wr_q    <= 1'b0;
      retry_q     <= 1'b0;
      resp_q      <= 1'b0;
      nxm_err_q   <= 1'b0;
      retry_out_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      resp_q      <= 1'b0;
      nxm_err_q   <= 1'b0;
      retry_out_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      if (enter_resp) begin
        resp_q      <= !retry_d;
        nxm_err_q   <= nxm_d && !retry_d;
        retry_out_q <= retry_d;
        rd_valid_q  <= rd_d && !nxm_d && !retry_d;
      end
      case (state_q)
        IDLE, PSE_HOLD: begin
          if (accept) begin
            idx_q    <= acc_idx;
            wdata_q  <= ebox.cacheDataWrite;
            rd_q     <= acc_rd;
            nxm_q    <= acc_nxm;
            pse_q    <= acc_rd && ebox.eboxPSE;
            pse_wr_q <= accept_pse;
            retry_q  <= acc_retry;
            cnt_q    <= CW'(LATENCY - 1);
            state_q  <= (LATENCY == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          if (retry_q) begin
            // A retried PSE write keeps its lock; anything else starts over.
            state_q <= pse_wr_q ? PSE_HOLD : IDLE;
          end else if (rd_q && pse_q && !nxm_q) begin
            state_q    <= PSE_HOLD;
            lock_idx_q <= idx_q;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ebox.cshEBOXT0     = accept;
  assign ebox.mboxRespIn    = resp_q;
  assign ebox.nxmErr        = nxm_err_q;
  assign ebox.cacheDataRead = rd_valid_q ? rdata_q : '0;
  assign ebox.cshEBOXRetry  = retry_out_q;
endmodule
